// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and nibble check for the digit-serial BCD adder.
// Imported by the adder top, its digit slice and the handshake interface users.
package bcd_pkg;

  localparam int          BCD_DIGIT_W   = 4;
  localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0]  BCD_CORR      = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // True when a nibble is not a legal decimal digit (A..F).
  function automatic logic bcd_nibble_bad(input logic [BCD_DIGIT_W-1:0] n);
    return n > BCD_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/bcd_serial_adder_if.sv
// Start/busy/done handshake plus operand and result buses of the BCD serial adder.
// The operand-entry side uses master; the adder itself uses slave.
interface bcd_serial_adder_if #(
  parameter int N_DIGITS = 4
);

  logic                  start;
  logic                  mode_sub;
  logic [4*N_DIGITS-1:0] a;
  logic [4*N_DIGITS-1:0] b;
  logic                  cin;
  logic                  busy;
  logic                  done;
  logic [4*N_DIGITS-1:0] sum;
  logic                  cout;
  logic                  err;

  modport master (
    output start, mode_sub, a, b, cin,
    input  busy, done, sum, cout, err
  );

  modport slave (
    input  start, mode_sub, a, b, cin,
    output busy, done, sum, cout, err
  );

endinterface

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder slice with +6 decimal correction.
// Flags either input nibble that is not a valid decimal digit.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] a_d,
  input  logic [BCD_DIGIT_W-1:0] b_d,
  input  logic                   c_in,
  output logic [BCD_DIGIT_W-1:0] s_d,
  output logic                   c_out,
  output logic                   invalid
);

  logic [BCD_DIGIT_W:0] raw;
  logic [BCD_DIGIT_W:0] corr;

  // Raw binary sum is 0..19; anything above 9 wraps into the next decade.
  assign raw     = {1'b0, a_d} + {1'b0, b_d} + {{BCD_DIGIT_W{1'b0}}, c_in};
  assign corr    = raw + {1'b0, BCD_CORR};
  assign c_out   = raw > {1'b0, BCD_MAX_DIGIT};
  assign s_d     = c_out ? corr[BCD_DIGIT_W-1:0] : raw[BCD_DIGIT_W-1:0];
  assign invalid = bcd_nibble_bad(a_d) || bcd_nibble_bad(b_d);

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder/subtractor: one digit per clock, LSD first.
// Subtraction uses nine's complement of B with an initial carry of 1 (ten's complement).
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_serial_adder_if.slave   bus
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  state_t state_q, state_d;

  logic [IDX_W-1:0]                         idx_q;
  logic [N_DIGITS-1:0][BCD_DIGIT_W-1:0]     a_q, b_q, sum_q;
  logic                                     sub_q, carry_q, cout_q, err_q;

  logic [N_DIGITS-1:0]    nib_bad;
  logic                   operands_bad;
  logic [BCD_DIGIT_W-1:0] b_eff, s_dig;
  logic                   c_next, slice_bad, last_digit;

  // Every nibble of both live operands is screened in the start cycle.
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_chk
    assign nib_bad[g] = bcd_nibble_bad(bus.a[g*BCD_DIGIT_W +: BCD_DIGIT_W]) ||
                        bcd_nibble_bad(bus.b[g*BCD_DIGIT_W +: BCD_DIGIT_W]);
  end
  assign operands_bad = |nib_bad;

  assign b_eff      = sub_q ? (BCD_MAX_DIGIT - b_q[idx_q]) : b_q[idx_q];
  assign last_digit = (idx_q == IDX_W'(N_DIGITS - 1));

  bcd_digit_add u_digit (
    .a_d     (a_q[idx_q]),
    .b_d     (b_eff),
    .c_in    (carry_q),
    .s_d     (s_dig),
    .c_out   (c_next),
    .invalid (slice_bad)
  );

  always_comb begin
    // NOTE: default assigned first so every path drives state_d; no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = operands_bad ? FIN : RUN;
      RUN:     if (last_digit) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            sub_q   <= bus.mode_sub;
            carry_q <= bus.mode_sub | bus.cin;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= operands_bad;
          end
        end
        RUN: begin
          sum_q[idx_q] <= s_dig;
          carry_q      <= c_next;
          err_q        <= err_q | slice_bad;
          if (last_digit) begin
            cout_q <= c_next;
            idx_q  <= '0;
          end else begin
            idx_q  <= idx_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == FIN);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder (N_DIGITS=4): vector table plus
// hand-written sequences for start-during-RUN, back-to-back start and mid-run reset.
module tb_bcd_serial_adder;

  localparam int N = 4;

  logic clk;
  logic rst_n;

  bcd_serial_adder_if #(.N_DIGITS(N)) bus ();

  bcd_serial_adder #(.N_DIGITS(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present operands, take one edge with start high, then scramble the inputs.
  task automatic launch(input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic cin);
    bus.a        = a;
    bus.b        = b;
    bus.mode_sub = sub;
    bus.cin      = cin;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.a        = ~a;
    bus.b        = ~b;
    bus.mode_sub = ~sub;
    bus.cin      = ~cin;
  endtask

  // Counts edges until done is seen (bounded) and busy cycles along the way.
  task automatic wait_done(output int lat, output int busy_n);
    lat    = 0;
    busy_n = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat, busy_n;
    int exp_lat;
    logic [15:0] held;
    exp_lat = v.err ? 0 : N;
    launch(v.a, v.b, v.sub, v.cin);
    wait_done(lat, busy_n);
    check({v.name, " done"},    32'(bus.done), 32'd1);
    check({v.name, " latency"}, 32'(lat),      32'(exp_lat));
    check({v.name, " busy"},    32'(busy_n),   32'(exp_lat));
    check({v.name, " sum"},     32'(bus.sum),  32'(v.sum));
    check({v.name, " cout"},    32'(bus.cout), 32'(v.cout));
    check({v.name, " err"},     32'(bus.err),  32'(v.err));
    held = bus.sum;
    @(posedge clk); #1;
    check({v.name, " done pulse"}, 32'(bus.done), 32'd0);
    check({v.name, " sum hold"},   32'(bus.sum),  32'(v.sum));
    check({v.name, " sum stable"}, 32'(bus.sum),  32'(held));
  endtask

  initial begin
    int lat, busy_n, done_seen;

    vecs[0] = '{"add 1234+5678",   16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0};
    vecs[1] = '{"add 9999+0001",   16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{"add 0+0+cin",     16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[3] = '{"sub 0500-0123",   16'h0500, 16'h0123, 1'b1, 1'b0, 16'h0377, 1'b1, 1'b0};
    vecs[4] = '{"sub 0123-0500",   16'h0123, 16'h0500, 1'b1, 1'b0, 16'h9623, 1'b0, 1'b0};
    vecs[5] = '{"sub 0500-0123 c", 16'h0500, 16'h0123, 1'b1, 1'b1, 16'h0377, 1'b1, 1'b0};
    vecs[6] = '{"sub 0123-0500 c", 16'h0123, 16'h0500, 1'b1, 1'b1, 16'h9623, 1'b0, 1'b0};
    vecs[7] = '{"add 9999+9999+c", 16'h9999, 16'h9999, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0};
    vecs[8] = '{"invalid 12A4",    16'h12A4, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[9] = '{"valid after err", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};

    rst_n        = 1'b1;
    bus.start    = 1'b0;
    bus.mode_sub = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.cin      = 1'b0;
    #3 rst_n = 1'b0;
    #2;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset sum",  32'(bus.sum),  32'd0);
    check("reset cout", 32'(bus.cout), 32'd0);
    check("reset err",  32'(bus.err),  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Sub 4321-4321: exact zero difference, no borrow.
    run_vec('{"sub equal", 16'h4321, 16'h4321, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0});

    // start pulsed during RUN with other operands must be ignored.
    launch(16'h1234, 16'h5678, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.a = 16'h9999; bus.b = 16'h9999; bus.mode_sub = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat, busy_n);
    check("ignore start done",    32'(bus.done), 32'd1);
    check("ignore start latency", 32'(lat),      32'd2);
    check("ignore start sum",     32'(bus.sum),  32'h6912);
    check("ignore start cout",    32'(bus.cout), 32'd0);

    // start held from the FIN cycle: ignored there, accepted in the following IDLE.
    bus.a = 16'h0500; bus.b = 16'h0123; bus.mode_sub = 1'b1; bus.cin = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    check("start in FIN busy", 32'(bus.busy), 32'd0);
    check("start in FIN done", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b accepted busy", 32'(bus.busy), 32'd1);
    wait_done(lat, busy_n);
    check("b2b done",    32'(bus.done), 32'd1);
    check("b2b latency", 32'(lat),      32'd4);
    check("b2b sum",     32'(bus.sum),  32'h0377);
    check("b2b cout",    32'(bus.cout), 32'd1);
    @(posedge clk); #1;

    // Asynchronous reset after digit 1 aborts the operation.
    launch(16'h1234, 16'h5678, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre-reset partial sum", 32'(bus.sum), 32'h0012);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort sum",  32'(bus.sum),  32'd0);
    check("abort cout", 32'(bus.cout), 32'd0);
    check("abort err",  32'(bus.err),  32'd0);
    done_seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done) done_seen++;
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.done) done_seen++;
    end
    check("no done after abort", 32'(done_seen), 32'd0);
    run_vec('{"after reset", 16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_serial_adder.md
Name: bcd_serial_adder

Overview:
Digit-serial packed-BCD adder/subtractor, generalised to N_DIGITS decimal digits. It processes one digit per clock, least-significant digit first, and applies the +6 decimal correction in each digit slice. It validates operands up front: any nibble greater than 9 raises an error. It sits behind the operand-entry logic and uses a start/busy/done handshake toward the result display path.

Parameters:
N_DIGITS, 4, number of BCD digits per operand (>=1); the data width is 4*N_DIGITS.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
mode_sub  input  1  0 = add (a+b+cin), 1 = subtract (a-b, ten's complement)
a  input  4*N_DIGITS  operand A, packed BCD, digit 0 in bits [3:0]
b  input  4*N_DIGITS  operand B, packed BCD
cin  input  1  decimal carry-in; ignored when mode_sub=1
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when the result is valid
sum  output  4*N_DIGITS  packed BCD result
cout  output  1  add: decimal carry-out; sub: 1 = no borrow (a>=b)
err  output  1  1 = an operand contained a nibble > 9

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, sum=0, cout=0, err=0, digit index=0. Reset mid-operation aborts the operation; no done is produced.
- States: IDLE, RUN, FIN.
- IDLE, start=1 at edge k:
  - latch a, b, mode_sub, and the effective carry (cin if add, 1 if sub).
  - evaluate validity of every nibble of a and b in the same cycle.
  - clear sum/cout/err.
  - valid -> RUN with index=0; invalid -> FIN with err=1, sum=0, cout=0.
- RUN: each cycle, processes digit i.
  - operand B digit = b_i (add) or 9-b_i (sub).
  - raw = a_i + bd + carry (5 bits, 0..19).
  - if raw>9: digit = (raw+6)[3:0] and carry=1; else digit = raw[3:0] and carry=0.
  - write sum[4i+3:4i]; index increments.
  - after digit N_DIGITS-1, cout=final carry and go to FIN.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE.
- Latency: valid operands give done high in the cycle after edge k+N_DIGITS; invalid operands give done high in the cycle after edge k.
- busy=1 in RUN only. start is ignored in RUN and FIN; no queuing.
- start asserted in the same cycle as FIN is ignored. start in the cycle after FIN (IDLE) is accepted, so back-to-back throughput is one operation per N_DIGITS+2 cycles.
- sum/cout/err hold their values after done until the next accepted start.
- Subtract with a<b: cout=0 and sum holds the ten's complement (10^N - (b-a)).
- Operand inputs may change freely after the start cycle; only latched copies are used.

Decomposition:
- Shared package bcd_pkg:
  - BCD_DIGIT_W=4 and BCD_MAX_DIGIT=9.
  - state enum {IDLE, RUN, FIN}.
  - BCD_CORR=6.
- Sub-module bcd_digit_add: combinational single-digit slice.
  - inputs: a_d[3:0], b_d[3:0], c_in.
  - outputs: s_d[3:0], c_out, invalid (either input nibble > 9).
  - instantiated once and time-multiplexed by the digit index.
  - validity checking in IDLE uses a generate loop of nibble comparators.

Test Plan:
1. N_DIGITS=4, add, a=1234, b=5678, cin=0 -> after 4 RUN cycles: sum=6912, cout=0, err=0, done one pulse; busy high exactly 4 cycles.
2. Add, a=9999, b=0001, cin=0 -> sum=0000, cout=1. Then a=0000, b=0000, cin=1 -> sum=0001, cout=0.
3. Sub, a=0500, b=0123 -> sum=0377, cout=1. Sub, a=0123, b=0500 -> sum=9623, cout=0; cin=1 must not change either result.
4. Invalid operand, a=12A4 (hex nibble A), b=0001 -> done in the cycle after the start edge, err=1, sum=0000, cout=0, busy never high. The next valid start clears err.
5. start pulsed during RUN with different operands -> ignored; the original result is delivered. start re-asserted immediately after done -> accepted, with a second correct result.
6. rst_n dropped asynchronously mid-RUN (after digit 1) -> busy/done/sum/cout/err go to 0 immediately, no done pulse follows, and the next start after release operates normally.
